// File: rtl/vx_elastic_stage_reg_pkg.sv
// rtl/vx_elastic_stage_reg_pkg.sv - shared state encoding for the elastic stage register
package vx_elastic_stage_reg_pkg;

    typedef logic [1:0] stage_state_t;

    // Encoding equals the number of held entries, so occupancy is the state itself.
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

endpackage

// File: rtl/vx_stage_slot.sv
// rtl/vx_stage_slot.sv - one storage slot of the elastic stage (load-enabled register)
module vx_stage_slot #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/vx_elastic_stage_reg.sv
// rtl/vx_elastic_stage_reg.sv - elastic pipeline stage with 2-entry skid buffer and warp flush
module vx_elastic_stage_reg
    import vx_elastic_stage_reg_pkg::*;
#(
    parameter int DATA_WIDTH = 512,
    parameter int NT         = 4,
    parameter int NW_BITS    = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [NT-1:0]         in_thread_mask,
    input  logic [NW_BITS-1:0]    in_warp_num,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [NT-1:0]         out_thread_mask,
    output logic [NW_BITS-1:0]    out_warp_num,
    input  logic                  flush_all,
    input  logic                  flush_warp_en,
    input  logic [NW_BITS-1:0]    flush_warp_num,
    output logic [1:0]            occupancy
);

    localparam int SW = DATA_WIDTH + NT + NW_BITS;

    stage_state_t  state;
    stage_state_t  state_d;
    logic          in_ready_q;
    logic [SW-1:0] in_word;
    logic [SW-1:0] main_q;
    logic [SW-1:0] skid_q;
    logic [SW-1:0] main_d;
    logic          main_load;
    logic          skid_load;
    logic          in_xfer;
    logic          out_xfer;
    logic          m_keep;
    logic          s_keep;
    logic          in_keep;

    assign in_word  = {in_data, in_thread_mask, in_warp_num};
    assign in_xfer  = in_valid & in_ready_q;
    assign out_xfer = out_valid & out_ready;

    // Survivors in FIFO order: main, skid, incoming. The head leaves first on out-xfer,
    // then the flush trims what remains; bubbles are acknowledged but never stored.
    always_comb begin
        m_keep  = (state != ST_EMPTY) && !out_xfer && !flush_all &&
                  !(flush_warp_en && (main_q[NW_BITS-1:0] == flush_warp_num));
        s_keep  = (state == ST_TWO) && !flush_all &&
                  !(flush_warp_en && (skid_q[NW_BITS-1:0] == flush_warp_num));
        in_keep = in_xfer && (|in_thread_mask) && !flush_all &&
                  !(flush_warp_en && (in_warp_num == flush_warp_num));

        main_load = !m_keep && (s_keep || in_keep);
        main_d    = s_keep ? skid_q : in_word;
        // A second survivor can only be the incoming entry behind a held main.
        skid_load = m_keep && in_keep;

        state_d = {1'b0, m_keep} + {1'b0, s_keep} + {1'b0, in_keep};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_EMPTY;
            in_ready_q <= 1'b0;
        end else begin
            state      <= state_d;
            in_ready_q <= (state_d != ST_TWO);
        end
    end

    vx_stage_slot #(.WIDTH(SW)) u_main_slot (
        .clk   (clk),
        .reset (reset),
        .load  (main_load),
        .d     (main_d),
        .q     (main_q)
    );

    vx_stage_slot #(.WIDTH(SW)) u_skid_slot (
        .clk   (clk),
        .reset (reset),
        .load  (skid_load),
        .d     (in_word),
        .q     (skid_q)
    );

    assign {out_data, out_thread_mask, out_warp_num} = main_q;
    assign out_valid = (state != ST_EMPTY);
    assign in_ready  = in_ready_q;
    assign occupancy = state;

endmodule

// File: tb/tb_vx_elastic_stage_reg.sv
// tb/tb_vx_elastic_stage_reg.sv - directed self-checking bench for vx_elastic_stage_reg
module tb_vx_elastic_stage_reg;

    localparam int DW = 16;
    localparam int NT = 4;
    localparam int NWB = 3;

    logic           clk = 1'b0;
    logic           reset;
    logic           in_valid;
    logic           in_ready;
    logic [DW-1:0]  in_data;
    logic [NT-1:0]  in_thread_mask;
    logic [NWB-1:0] in_warp_num;
    logic           out_valid;
    logic           out_ready;
    logic [DW-1:0]  out_data;
    logic [NT-1:0]  out_thread_mask;
    logic [NWB-1:0] out_warp_num;
    logic           flush_all;
    logic           flush_warp_en;
    logic [NWB-1:0] flush_warp_num;
    logic [1:0]     occupancy;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    vx_elastic_stage_reg #(.DATA_WIDTH(DW), .NT(NT), .NW_BITS(NWB)) dut (
        .clk             (clk),
        .reset           (reset),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_data         (in_data),
        .in_thread_mask  (in_thread_mask),
        .in_warp_num     (in_warp_num),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_data        (out_data),
        .out_thread_mask (out_thread_mask),
        .out_warp_num    (out_warp_num),
        .flush_all       (flush_all),
        .flush_warp_en   (flush_warp_en),
        .flush_warp_num  (flush_warp_num),
        .occupancy       (occupancy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [DW-1:0] d, input logic [NT-1:0] m, input logic [NWB-1:0] w);
        in_valid       = 1'b1;
        in_data        = d;
        in_thread_mask = m;
        in_warp_num    = w;
    endtask

    task automatic idle_in();
        in_valid       = 1'b0;
        in_data        = '0;
        in_thread_mask = '0;
        in_warp_num    = '0;
    endtask

    initial begin
        reset          = 1'b1;
        out_ready      = 1'b0;
        flush_all      = 1'b0;
        flush_warp_en  = 1'b0;
        flush_warp_num = '0;
        idle_in();
        tick();
        tick();
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_occ", {30'd0, occupancy}, 32'd0);
        chk("rst_out_data", {16'd0, out_data}, 32'd0);
        chk("rst_out_mask", {28'd0, out_thread_mask}, 32'd0);
        chk("rst_out_warp", {29'd0, out_warp_num}, 32'd0);
        reset = 1'b0;
        tick();
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Streaming: 8 back-to-back entries, one-cycle latency, no gaps
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            offer(DW'(i), 4'hF, 3'd0);
            tick();
            chk("stream_valid", {31'd0, out_valid}, 32'd1);
            chk("stream_data", {16'd0, out_data}, i);
            chk("stream_ready", {31'd0, in_ready}, 32'd1);
        end
        idle_in();
        tick();
        chk("stream_end_valid", {31'd0, out_valid}, 32'd0);
        chk("stream_end_occ", {30'd0, occupancy}, 32'd0);

        // Backpressure: A,B accepted, C stalls, then A,B,C drain in order
        out_ready = 1'b0;
        offer(16'h00A1, 4'hF, 3'd1);
        tick();
        chk("bp_a_occ", {30'd0, occupancy}, 32'd1);
        chk("bp_a_data", {16'd0, out_data}, 32'h00A1);
        offer(16'h00B1, 4'hF, 3'd1);
        tick();
        chk("bp_b_occ", {30'd0, occupancy}, 32'd2);
        chk("bp_b_ready", {31'd0, in_ready}, 32'd0);
        offer(16'h00C1, 4'hF, 3'd1);
        tick();
        chk("bp_c_occ", {30'd0, occupancy}, 32'd2);
        chk("bp_c_ready", {31'd0, in_ready}, 32'd0);
        chk("bp_c_head", {16'd0, out_data}, 32'h00A1);
        out_ready = 1'b1;
        tick();
        chk("bp_rel_data", {16'd0, out_data}, 32'h00B1);
        chk("bp_rel_occ", {30'd0, occupancy}, 32'd1);
        chk("bp_rel_ready", {31'd0, in_ready}, 32'd1);
        tick();
        chk("bp_c_data", {16'd0, out_data}, 32'h00C1);
        chk("bp_c_occ1", {30'd0, occupancy}, 32'd1);
        idle_in();
        tick();
        chk("bp_end_valid", {31'd0, out_valid}, 32'd0);
        chk("bp_hold_data", {16'd0, out_data}, 32'h00C1);

        // Bubble: handshake completes, nothing stored
        out_ready = 1'b0;
        offer(16'h0055, 4'h0, 3'd1);
        tick();
        chk("bub_empty_occ", {30'd0, occupancy}, 32'd0);
        chk("bub_empty_valid", {31'd0, out_valid}, 32'd0);
        chk("bub_empty_ready", {31'd0, in_ready}, 32'd1);
        offer(16'h00D0, 4'h3, 3'd1);
        tick();
        offer(16'h0066, 4'h0, 3'd1);
        tick();
        chk("bub_one_occ", {30'd0, occupancy}, 32'd1);
        chk("bub_one_data", {16'd0, out_data}, 32'h00D0);
        chk("bub_one_mask", {28'd0, out_thread_mask}, 32'h3);
        idle_in();
        out_ready = 1'b1;
        tick();
        chk("bub_drain_occ", {30'd0, occupancy}, 32'd0);

        // Warp flush: main warp2 removed, skid warp5 compacts into main
        out_ready = 1'b0;
        offer(16'h00E2, 4'hF, 3'd2);
        tick();
        offer(16'h00F5, 4'hF, 3'd5);
        tick();
        chk("wf_pre_occ", {30'd0, occupancy}, 32'd2);
        idle_in();
        flush_warp_en  = 1'b1;
        flush_warp_num = 3'd2;
        tick();
        chk("wf_occ", {30'd0, occupancy}, 32'd1);
        chk("wf_data", {16'd0, out_data}, 32'h00F5);
        chk("wf_warp", {29'd0, out_warp_num}, 32'd5);
        chk("wf_ready", {31'd0, in_ready}, 32'd1);
        offer(16'h0072, 4'hF, 3'd2);
        tick();
        chk("wf_in_occ", {30'd0, occupancy}, 32'd1);
        chk("wf_in_data", {16'd0, out_data}, 32'h00F5);
        flush_warp_en = 1'b0;
        idle_in();
        out_ready = 1'b1;
        tick();
        chk("wf_drain_occ", {30'd0, occupancy}, 32'd0);

        // flush_all concurrent with out-xfer and in-xfer
        out_ready = 1'b0;
        offer(16'h0081, 4'hF, 3'd1);
        tick();
        offer(16'h0099, 4'hF, 3'd3);
        out_ready = 1'b1;
        flush_all = 1'b1;
        chk("fa_head_valid", {31'd0, out_valid}, 32'd1);
        chk("fa_head_data", {16'd0, out_data}, 32'h0081);
        chk("fa_in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        chk("fa_occ", {30'd0, occupancy}, 32'd0);
        chk("fa_valid", {31'd0, out_valid}, 32'd0);
        flush_all = 1'b0;
        out_ready = 1'b0;
        offer(16'h0011, 4'hF, 3'd4);
        tick();
        offer(16'h0022, 4'hF, 3'd6);
        tick();
        idle_in();
        out_ready = 1'b1;
        flush_all = 1'b1;
        tick();
        chk("fa2_occ", {30'd0, occupancy}, 32'd0);
        chk("fa2_ready", {31'd0, in_ready}, 32'd1);
        flush_all = 1'b0;
        offer(16'h0033, 4'hF, 3'd7);
        tick();
        chk("fa2_next_data", {16'd0, out_data}, 32'h0033);
        chk("fa2_next_warp", {29'd0, out_warp_num}, 32'd7);

        // Asynchronous reset with two entries held
        out_ready = 1'b0;
        offer(16'h0044, 4'hF, 3'd1);
        tick();
        chk("ar_pre_occ", {30'd0, occupancy}, 32'd2);
        #2;
        reset = 1'b1;
        #1;
        chk("ar_valid", {31'd0, out_valid}, 32'd0);
        chk("ar_occ", {30'd0, occupancy}, 32'd0);
        chk("ar_data", {16'd0, out_data}, 32'd0);
        idle_in();
        tick();
        reset = 1'b0;
        tick();
        chk("ar_in_ready", {31'd0, in_ready}, 32'd1);
        chk("ar_post_occ", {30'd0, occupancy}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
